// File: rtl/debounce_bank_pkg.sv
// debounce_bank_pkg: default parameters, counter width helper and per-channel output bundle
package debounce_bank_pkg;
    localparam int DEFAULT_N_CH        = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_DIV         = 1000;
    localparam int DEFAULT_STABLE_N    = 8;
    localparam int DEFAULT_HOLD_N      = 500;

    function automatic int clog2_min1(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic held;
    } chan_out_t;
endpackage

// File: rtl/debounce_bank_chan.sv
// debounce_bank_chan: one channel - synchroniser, tick-sampled stability filter, long-press counter
module debounce_bank_chan
    import debounce_bank_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int STABLE_N    = DEFAULT_STABLE_N,
    parameter int HOLD_N      = DEFAULT_HOLD_N
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      tick,
    input  logic      btn,
    output chan_out_t out
);
    localparam int SW = clog2_min1(STABLE_N + 1);
    localparam int HW = clog2_min1(HOLD_N + 1);
    localparam logic [SW-1:0] S_LAST = SW'(STABLE_N - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(HOLD_N);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SW-1:0]          scnt_q, scnt_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    chan_out_t              out_q, out_d;
    logic                   s, accept;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], btn};
        s           = sync_q[SYNC_STAGES-1];
        accept      = tick && (s != out_q.level) && (scnt_q == S_LAST);
        scnt_d      = !tick ? scnt_q : (s == out_q.level || accept) ? '0 : scnt_q + SW'(1);
        out_d.level = accept ? s : out_q.level;
        out_d.rise  = accept && s;
        out_d.fall  = accept && !s;
        hcnt_d      = !out_d.level ? '0 : (tick && out_q.level && hcnt_q != H_MAX) ? hcnt_q + HW'(1) : hcnt_q;
        out_d.held  = hcnt_d == H_MAX;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            scnt_q <= '0;
            hcnt_q <= '0;
            out_q  <= '0;
        end else begin
            sync_q <= sync_d;
            scnt_q <= scnt_d;
            hcnt_q <= hcnt_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N-channel button conditioner sharing one sample prescaler across all channels
module debounce_bank
    import debounce_bank_pkg::*;
#(
    parameter int N_CH        = DEFAULT_N_CH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int DIV         = DEFAULT_DIV,
    parameter int STABLE_N    = DEFAULT_STABLE_N,
    parameter int HOLD_N      = DEFAULT_HOLD_N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] held,
    output logic            sample_tick
);
    localparam int PW = clog2_min1(DIV);
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          tick_q, tick_d;
    chan_out_t     chan_out [N_CH];

    always_comb begin
        pcnt_d = (pcnt_q == P_LAST) ? '0 : pcnt_q + PW'(1);
        tick_d = pcnt_q == P_LAST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            tick_q <= tick_d;
        end
    end

    assign sample_tick = tick_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        debounce_bank_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .STABLE_N   (STABLE_N),
            .HOLD_N     (HOLD_N)
        ) u_chan (
            .clk (clk),
            .rst (rst),
            .tick(tick_q),
            .btn (btn_in[i]),
            .out (chan_out[i])
        );
        assign level[i] = chan_out[i].level;
        assign rise[i]  = chan_out[i].rise;
        assign fall[i]  = chan_out[i].fall;
        assign held[i]  = chan_out[i].held;
    end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: two builds (slow prescaler and DIV=1/STABLE_N=1) checked against a sample-history model
module tb_debounce_bank;
    localparam int N    = 4;
    localparam int SYNC = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] a_level, a_rise, a_fall, a_held;
    logic [N-1:0] b_level, b_rise, b_fall, b_held;
    logic         a_tick, b_tick;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    debounce_bank #(.N_CH(N), .SYNC_STAGES(SYNC), .DIV(4), .STABLE_N(8), .HOLD_N(16)) dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_in), .level(a_level), .rise(a_rise),
        .fall(a_fall), .held(a_held), .sample_tick(a_tick)
    );

    debounce_bank #(.N_CH(N), .SYNC_STAGES(SYNC), .DIV(1), .STABLE_N(1), .HOLD_N(2)) dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_in), .level(b_level), .rise(b_rise),
        .fall(b_fall), .held(b_held), .sample_tick(b_tick)
    );

    int div_p[2]  = '{4, 1};
    int stab_p[2] = '{8, 1};
    int hold_p[2] = '{16, 2};
    int ecount[2];
    bit m_tick[2];
    bit m_level[2][N], m_rise[2][N], m_fall[2][N], m_held[2][N];
    int hticks[2][N];
    bit syncq[2][N][$];
    bit samp[2][N][$];

    // Level changes once the newest STABLE_N tick samples since the last change all disagree with it.
    task automatic step(int u);
        bit s, tick_before, all_diff;
        if (rst) begin
            ecount[u] = 0;
            m_tick[u] = 0;
            for (int c = 0; c < N; c++) begin
                syncq[u][c].delete();
                for (int j = 0; j < SYNC; j++) syncq[u][c].push_back(1'b0);
                samp[u][c].delete();
                m_level[u][c] = 0; m_rise[u][c] = 0; m_fall[u][c] = 0; m_held[u][c] = 0;
                hticks[u][c] = 0;
            end
        end else begin
            tick_before = m_tick[u];
            ecount[u]++;
            m_tick[u] = (ecount[u] % div_p[u]) == 0;
            for (int c = 0; c < N; c++) begin
                s = syncq[u][c].pop_front();
                syncq[u][c].push_back(btn_in[c]);
                m_rise[u][c] = 0;
                m_fall[u][c] = 0;
                if (tick_before) begin
                    if (m_level[u][c]) hticks[u][c]++;
                    samp[u][c].push_back(s);
                    if (samp[u][c].size() > stab_p[u]) void'(samp[u][c].pop_front());
                    all_diff = samp[u][c].size() == stab_p[u];
                    foreach (samp[u][c][j]) if (samp[u][c][j] == m_level[u][c]) all_diff = 0;
                    if (all_diff) begin
                        m_level[u][c] = !m_level[u][c];
                        m_rise[u][c]  = m_level[u][c];
                        m_fall[u][c]  = !m_level[u][c];
                        samp[u][c].delete();
                    end
                end
                if (!m_level[u][c]) hticks[u][c] = 0;
                m_held[u][c] = m_level[u][c] && hticks[u][c] >= hold_p[u];
            end
        end
    endtask

    always @(posedge clk) for (int u = 0; u < 2; u++) step(u);

    task automatic cyc();
        logic [16:0] got, exp_v;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            got = (u == 0) ? {a_tick, a_level, a_rise, a_fall, a_held}
                           : {b_tick, b_level, b_rise, b_fall, b_held};
            exp_v[16] = m_tick[u];
            for (int c = 0; c < N; c++) begin
                exp_v[12+c] = m_level[u][c];
                exp_v[8+c]  = m_rise[u][c];
                exp_v[4+c]  = m_fall[u][c];
                exp_v[c]    = m_held[u][c];
            end
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL model_dut%0d tick/level/rise/fall/held got=%h expected=%h at %0t", u, got, exp_v, $time);
            end
        end
    endtask

    task automatic chk(bit ok, string name, int got, int exp_v);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp_v);
        end
    endtask

    initial begin
        int n, pulses, rate, lim;
        logic [7:0] pat;
        logic [N-1:0] mask;
        repeat (3) cyc();
        chk(a_level == 0 && a_rise == 0 && a_fall == 0 && a_held == 0 && a_tick == 0,
            "reset_outputs", int'({a_level, a_rise, a_fall, a_held, a_tick}), 0);
        rst = 1'b0;
        pat = '0;
        repeat (8) begin
            cyc();
            pat = {pat[6:0], a_tick};
        end
        chk(pat == 8'b0001_0001, "tick_every_4th", int'(pat), 17);

        btn_in[0] = 1'b1;
        n = 0;
        pulses = 0;
        while (!a_level[0] && n < 60) begin
            cyc();
            n++;
            pulses += int'(a_rise[0]);
        end
        chk(n >= 31 && n <= 35, "rise_latency", n, 33);
        chk(pulses == 1, "rise0_single_pulse", pulses, 1);
        chk(a_level[3:1] == 0 && a_rise[3:1] == 0, "others_idle", int'(a_level), 1);

        n = 0;
        while (!a_held[0] && n < 100) begin
            cyc();
            n++;
        end
        chk(n == 64, "held_after_16_ticks", n, 64);
        repeat (10) cyc();
        btn_in[0] = 1'b0;
        n = 0;
        while (!a_fall[0] && n < 60) begin
            cyc();
            n++;
        end
        chk(a_fall[0] && !a_held[0] && !a_level[0], "fall_clears_held", int'({a_fall[0], a_held[0], a_level[0]}), 4);
        cyc();
        chk(!a_fall[0], "fall_one_cycle", int'(a_fall[0]), 0);

        pulses = 0;
        for (int t = 0; t < 200; t++) begin
            if (t % 6 == 0) btn_in[1] = ~btn_in[1];
            cyc();
            pulses += int'(a_level[1]) + int'(a_rise[1]) + int'(a_fall[1]);
        end
        chk(pulses == 0, "bounce_rejected", pulses, 0);

        repeat (40) cyc();
        btn_in = '1;
        n = 0;
        while (a_rise == 0 && n < 60) begin
            cyc();
            n++;
        end
        chk(a_rise == 4'b1111, "simultaneous_rise", int'(a_rise), 15);
        repeat (5) cyc();
        rst = 1'b1;
        cyc();
        chk(a_level == 0 && a_fall == 0 && a_rise == 0, "reset_mid_press_no_fall", int'({a_level, a_fall}), 0);
        rst = 1'b0;
        n = 0;
        while (a_level != 4'b1111 && n < 60) begin
            cyc();
            n++;
        end
        chk(n <= 35 && a_rise == 4'b1111, "reacquire_after_reset", n, 33);

        repeat (5) cyc();
        btn_in[2] = 1'b0;
        cyc();
        cyc();
        chk(b_level[2] == 1'b1, "divone_not_yet_at_2clk", int'(b_level[2]), 1);
        cyc();
        chk(!b_level[2] && b_fall[2], "divone_fall_at_3clk", int'({b_level[2], b_fall[2]}), 1);
        btn_in[2] = 1'b1;
        repeat (3) cyc();
        chk(b_level[2] && b_rise[2], "divone_rise_at_3clk", int'({b_level[2], b_rise[2]}), 3);

        for (int seg = 0; seg < 40; seg++) begin
            rate = $urandom_range(0, 3);
            lim = (rate == 3) ? 1 : (rate == 2) ? 7 : 63;
            repeat (50) begin
                for (int c = 0; c < N; c++) mask[c] = rate != 0 && $urandom_range(0, lim) == 0;
                btn_in = btn_in ^ mask;
                rst = $urandom_range(0, 599) == 0;
                cyc();
            end
        end
        rst = 1'b0;
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
